// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one adder_full cell, LSB first, carry kept in a flop; done pulses WIDTH+1 cycles after accept.
// No backpressure: start is honoured only in IDLE/DONE and ignored while busy.
`timescale 1ns/1ps
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0] opa, opb, acc;
  logic             carry;
  logic [CW-1:0]    count;
  logic             cell_sum, cell_carry;
  logic             accept, last_bit;

  adder_full u_cell (
    .a        (opa[0]),
    .b        (opb[0]),
    .incarry  (carry),
    .sum      (cell_sum),
    .outcarry (cell_carry)
  );

  // DONE accepts a new request just like IDLE, giving back-to-back adds.
  assign accept   = start && ((state == IDLE) || (state == DONE));
  assign last_bit = (state == SHIFT) && (count == CW'(WIDTH - 1));
  assign busy     = (state == SHIFT);
  assign done     = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (count == CW'(WIDTH - 1)) state_nxt = DONE;
      DONE:    state_nxt = start ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa     <= '0;
      opb     <= '0;
      acc     <= '0;
      carry   <= 1'b0;
      count   <= '0;
      sum_out <= '0;
      cout    <= 1'b0;
    end else begin
      if (accept) begin
        opa   <= a_in;
        opb   <= b_in;
        carry <= cin;
        count <= '0;
        acc   <= '0;
      end else if (state == SHIFT) begin
        opa   <= {1'b0, opa[WIDTH-1:1]};
        opb   <= {1'b0, opb[WIDTH-1:1]};
        acc   <= {cell_sum, acc[WIDTH-1:1]};
        carry <= cell_carry;
        count <= count + CW'(1);
      end
      // Results only move on the completing edge, so they hold between adds.
      if (last_bit) begin
        sum_out <= {cell_sum, acc[WIDTH-1:1]};
        cout    <= cell_carry;
      end
    end
  end
endmodule

module adder_full (
  input  logic a,
  input  logic b,
  input  logic incarry,
  output logic sum,
  output logic outcarry
);
  assign sum      = a ^ b ^ incarry;
  assign outcarry = (a & b) | (incarry & (a ^ b));
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench: accepts are predicted from timing rules, results from plain integer addition.
`timescale 1ns/1ps
module tb_serial_adder_ctrl;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a_in = '0;
  logic [WIDTH-1:0] b_in = '0;
  logic             cin = 1'b0;
  logic             busy, done, cout;
  logic [WIDTH-1:0] sum_out;

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in), .cin(cin),
    .busy(busy), .done(done), .sum_out(sum_out), .cout(cout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH:0] res;
    int             dcyc;
  } exp_t;

  exp_t           q[$];
  int             cyc = 0;
  int             next_ok = 0;
  int             errors = 0;
  int             checks = 0;
  logic [WIDTH:0] last_res = '0;
  logic           prev_done = 1'b0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Reference: an add is accepted when start is seen and the previous one has
  // finished (WIDTH+1 cycles since its accept); result is plain addition.
  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      next_ok <= 0;
    end else if (start && cyc >= next_ok) begin
      q.push_back('{res: ({1'b0, a_in} + {1'b0, b_in} + {{WIDTH{1'b0}}, cin}),
                    dcyc: cyc + WIDTH + 1});
      next_ok <= cyc + WIDTH + 1;
    end
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_result", 64'({cout, sum_out}), 64'd0);
      last_res  <= '0;
      prev_done <= 1'b0;
    end else begin
      check("busy", 64'(busy), 64'((q.size() > 0) && (cyc < q[0].dcyc)));
      check("done_width", 64'(done && prev_done), 64'd0);
      prev_done <= done;
      if (done) begin
        if (q.size() == 0) begin
          check("unexpected_done", 64'(done), 64'd0);
          check("result_hold", 64'({cout, sum_out}), 64'(last_res));
        end else begin
          check("result", 64'({cout, sum_out}), 64'(q[0].res));
          check("done_cycle", 64'(cyc), 64'(q[0].dcyc));
          last_res <= q[0].res;
          void'(q.pop_front());
        end
      end else begin
        check("result_hold", 64'({cout, sum_out}), 64'(last_res));
        if (q.size() > 0 && cyc >= q[0].dcyc) begin
          check("missing_done", 64'(done), 64'd1);
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic pulse_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
    @(negedge clk);
    a_in = a; b_in = b; cin = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a_in = WIDTH'($urandom); b_in = WIDTH'($urandom); cin = 1'($urandom);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    pulse_op(8'h3C, 8'h42, 1'b0);
    repeat (WIDTH) @(negedge clk);
    pulse_op(8'hFF, 8'h01, 1'b0);
    repeat (WIDTH) @(negedge clk);
    pulse_op(8'hA5, 8'h5A, 1'b1);
    repeat (WIDTH) @(negedge clk);

    // start held high: second accept picks up the changed operands.
    @(negedge clk);
    a_in = 8'h01; b_in = 8'h01; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    a_in = 8'h80; b_in = 8'h80;
    repeat (9) @(negedge clk);
    start = 1'b0;
    repeat (WIDTH) @(negedge clk);

    // A mid-SHIFT request must be ignored.
    pulse_op(8'h37, 8'h19, 1'b1);
    repeat (2) @(negedge clk);
    a_in = 8'hEE; b_in = 8'hDD; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (WIDTH) @(negedge clk);

    // Asynchronous reset part-way through an add.
    pulse_op(8'hF0, 8'h0F, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_done", 64'(done), 64'd0);
    check("async_rst_result", 64'({cout, sum_out}), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pulse_op(8'hF0, 8'h0F, 1'b0);
    repeat (WIDTH + 1) @(negedge clk);

    // Random traffic, including requests that land while busy.
    for (int i = 0; i < 11000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) != 0);
      a_in  = WIDTH'($urandom);
      b_in  = WIDTH'($urandom);
      cin   = 1'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (WIDTH + 3) @(negedge clk);
    check("queue_drained", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
